rob_commit: RTL and testbench
=============================

ROB_COMMIT -- requirements
Module: rob_commit

Interface
REQ-001 Parameters (name, default, meaning):
- COMMIT_WIDTH, 4, retire lanes per cycle.
- ROB_ID_WIDTH, 5, ROB index width; ROB holds 2^ROB_ID_WIDTH entries.
- PHY_REG_ID_WIDTH, 6, physical register id width.
REQ-002 Ports (name, direction, width, meaning):
- clk  in  1  clock.
- rst  in  1  reset, synchronous, active-high.
- rob_commit_retire_head_id  in  ROB_ID_WIDTH  oldest ROB entry.
- rob_commit_retire_head_id_valid  in  1  ROB non-empty.
- commit_rob_retire_id[i]  out  COMMIT_WIDTH x ROB_ID_WIDTH  lane read ids.
- rob_commit_retire_data[i]  in  COMMIT_WIDTH x rob_item_t  lane entries.
- rob_commit_retire_id_valid  in  COMMIT_WIDTH  lane id occupied.
- commit_rob_retire_pop  out  COMMIT_WIDTH  lane retired this cycle.
- rob_commit_flush_tail_id / _valid  in  ROB_ID_WIDTH / 1  youngest entry.
- commit_rob_flush_id  out  ROB_ID_WIDTH  walk pointer.
- rob_commit_flush_data  in  rob_item_t  entry at walk pointer.
- rob_commit_flush_next_id / _valid  in  ROB_ID_WIDTH / 1  next-older entry.
- commit_rob_flush  out  1  ROB pointer reset pulse.
- commit_free_id[i] / commit_free_valid  out  COMMIT_WIDTH x PHY_REG_ID_WIDTH / COMMIT_WIDTH  phys regs released to freelist.
- commit_rat_restore_arch / _phy / _valid  out  5 / PHY_REG_ID_WIDTH / 1  rename-table rollback.
- commit_redirect_pc / commit_redirect_valid  out  32 / 1  exception redirect to fetch.
- commit_retired_num  out  clog2(COMMIT_WIDTH)+1  retire count (minstret).
REQ-003 rob_item_t fields used: finish, has_exception, pc, rd_valid, rd_arch_id, new_phy_id, old_phy_id.

Function
REQ-004 FSM states: NORMAL, WALK, DONE; encoding internal.
REQ-005 commit_rob_retire_id[i] = head_id + i, modulo 2^ROB_ID_WIDTH (wraps 31->0).
REQ-006 NORMAL: lane i eligible = retire_id_valid[i] & finish & !has_exception & lane i-1 popped (lane 0 needs head_id_valid); pop[i] = eligible; contiguous-prefix only, no gaps.
REQ-007 NORMAL: popped lane with rd_valid=1 -> commit_free_valid[i]=1, commit_free_id[i]=old_phy_id, same cycle as pop.
REQ-008 commit_retired_num = popcount(pop), combinational.
REQ-009 NORMAL: lane 0 valid & finish & has_exception -> pop=0 all lanes; latch pc into pc_reg; latch flush_tail_id into walk_ptr; next state WALK.
REQ-010 WALK: commit_rob_flush_id = walk_ptr; if flush_data.rd_valid: commit_rat_restore_valid=1 with arch=rd_arch_id, phy=old_phy_id, and commit_free_valid[0]=1 with free_id[0]=new_phy_id; one entry per cycle, youngest first; excepting entry included.
REQ-011 WALK: flush_next_id_valid=1 -> walk_ptr <= flush_next_id, stay; =0 -> next state DONE.
REQ-012 DONE: commit_rob_flush=1 and commit_redirect_valid=1 with commit_redirect_pc=pc_reg, for exactly one cycle; next state NORMAL.
REQ-013 WALK/DONE: pop=0, retired_num=0; no NORMAL retirement.
REQ-014 commit_rob_flush_id in NORMAL = flush_tail_id (don't-care to ROB); all other outputs not listed active are 0.
REQ-015 Empty ROB (head_id_valid=0) in NORMAL: no pop, state unchanged.
REQ-016 Full ROB: walk terminates on next_id_valid=0 only, never on id compare; walk length = occupancy.
REQ-017 Unfinished lane blocks all younger lanes even if they are finished.

Reset
REQ-018 rst=1 at posedge: state<=NORMAL, walk_ptr<=0, pc_reg<=0; reset dominates any state incl. mid-WALK; no flush/redirect pulse issued for an aborted walk.
REQ-019 While rst=1 all outputs 0 except commit_rob_retire_id (combinational from head_id).

Verification
REQ-020 Head=30, 4 finished no-exception entries, rd_valid all 1 -> ids 30,31,0,1; pop=1111; retired_num=4; free_id = each old_phy_id.
REQ-021 Head=5, lanes finish=1,0,1,1 -> pop=0001, retired_num=1, lanes 2-3 not popped.
REQ-022 Head=3 exception pc=0x80000100, tail=6, all rd_valid -> WALK cycles restore ids 6,5,4,3 in order; next cycle DONE: commit_rob_flush=1, redirect_pc=0x80000100; then NORMAL.
REQ-023 Full ROB (32 entries) exception at head -> exactly 32 WALK cycles, then one DONE pulse.
REQ-024 rst asserted on 2nd WALK cycle -> next cycle NORMAL, no commit_rob_flush/redirect pulse, all valids 0.
REQ-025 Empty ROB for 10 cycles -> pop=0, retired_num=0, state NORMAL throughout.

Source files
------------

// File: rtl/rob_commit.sv
// Commit stage: retires up to COMMIT_WIDTH finished ROB entries per cycle in program order and, on
// an exception at the head, walks the ROB youngest-to-oldest to roll back renaming.
// A rob_item_t is carried as a packed vector. Fields from MSB to LSB:
// {finish, has_exception, pc[31:0], rd_valid, rd_arch_id[4:0], new_phy_id, old_phy_id}.
module rob_commit #(
  parameter int unsigned COMMIT_WIDTH     = 4,
  parameter int unsigned ROB_ID_WIDTH     = 5,
  parameter int unsigned PHY_REG_ID_WIDTH = 6,
  localparam int unsigned ItemW           = 2 * PHY_REG_ID_WIDTH + 40,
  localparam int unsigned NumW            = $clog2(COMMIT_WIDTH) + 1
) (
  input  logic                                     clk,
  input  logic                                     rst,
  input  logic [ROB_ID_WIDTH-1:0]                  rob_commit_retire_head_id,
  input  logic                                     rob_commit_retire_head_id_valid,
  output logic [COMMIT_WIDTH*ROB_ID_WIDTH-1:0]     commit_rob_retire_id,
  input  logic [COMMIT_WIDTH*ItemW-1:0]            rob_commit_retire_data,
  input  logic [COMMIT_WIDTH-1:0]                  rob_commit_retire_id_valid,
  output logic [COMMIT_WIDTH-1:0]                  commit_rob_retire_pop,
  input  logic [ROB_ID_WIDTH-1:0]                  rob_commit_flush_tail_id,
  input  logic                                     rob_commit_flush_tail_id_valid,
  output logic [ROB_ID_WIDTH-1:0]                  commit_rob_flush_id,
  input  logic [ItemW-1:0]                         rob_commit_flush_data,
  input  logic [ROB_ID_WIDTH-1:0]                  rob_commit_flush_next_id,
  input  logic                                     rob_commit_flush_next_id_valid,
  output logic                                     commit_rob_flush,
  output logic [COMMIT_WIDTH*PHY_REG_ID_WIDTH-1:0] commit_free_id,
  output logic [COMMIT_WIDTH-1:0]                  commit_free_valid,
  output logic [4:0]                               commit_rat_restore_arch,
  output logic [PHY_REG_ID_WIDTH-1:0]              commit_rat_restore_phy,
  output logic                                     commit_rat_restore_valid,
  output logic [31:0]                              commit_redirect_pc,
  output logic                                     commit_redirect_valid,
  output logic [NumW-1:0]                          commit_retired_num
);

  localparam int unsigned P       = PHY_REG_ID_WIDTH;
  localparam int unsigned OldLsb  = 0;
  localparam int unsigned NewLsb  = P;
  localparam int unsigned ArchLsb = 2 * P;
  localparam int unsigned RdvBit  = 2 * P + 5;
  localparam int unsigned PcLsb   = 2 * P + 6;
  localparam int unsigned ExcBit  = 2 * P + 38;
  localparam int unsigned FinBit  = 2 * P + 39;

  typedef enum logic [1:0] {StNormal, StWalk, StDone} state_e;

  state_e                  r_state, w_state_next;
  logic [ROB_ID_WIDTH-1:0] r_walk_ptr, w_walk_ptr_next;
  logic [31:0]             r_pc, w_pc_next;
  logic [ItemW-1:0]        w_lane [COMMIT_WIDTH];
  logic                    w_head_exc;
  logic                    w_unused;

  always_comb begin
    for (int i = 0; i < COMMIT_WIDTH; i++) begin
      w_lane[i] = rob_commit_retire_data[i*ItemW +: ItemW];
    end
  end

  // Only a finished excepting head triggers the walk; an excepting younger lane just blocks.
  assign w_head_exc = rob_commit_retire_head_id_valid & rob_commit_retire_id_valid[0] &
                      w_lane[0][FinBit] & w_lane[0][ExcBit];

  assign w_unused = ^{rob_commit_flush_tail_id_valid, rob_commit_retire_data,
                      rob_commit_flush_data};

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= StNormal;
      r_walk_ptr <= '0;
      r_pc       <= '0;
    end else begin
      r_state    <= w_state_next;
      r_walk_ptr <= w_walk_ptr_next;
      r_pc       <= w_pc_next;
    end
  end

  // Walk ends only when the ROB reports no older entry, so a full ROB walks every entry.
  always_comb begin
    w_state_next    = r_state;
    w_walk_ptr_next = r_walk_ptr;
    w_pc_next       = r_pc;
    unique case (r_state)
      StNormal: begin
        if (w_head_exc) begin
          w_state_next    = StWalk;
          w_walk_ptr_next = rob_commit_flush_tail_id;
          w_pc_next       = w_lane[0][PcLsb +: 32];
        end
      end
      StWalk: begin
        if (rob_commit_flush_next_id_valid) begin
          w_walk_ptr_next = rob_commit_flush_next_id;
        end else begin
          w_state_next = StDone;
        end
      end
      StDone:  w_state_next = StNormal;
      default: w_state_next = StNormal;
    endcase
  end

  always_comb begin
    logic w_chain;
    w_chain                  = 1'b0;
    commit_rob_retire_pop    = '0;
    commit_free_valid        = '0;
    commit_free_id           = '0;
    commit_rat_restore_valid = 1'b0;
    commit_rat_restore_arch  = '0;
    commit_rat_restore_phy   = '0;
    commit_rob_flush         = 1'b0;
    commit_redirect_valid    = 1'b0;
    commit_redirect_pc       = '0;
    commit_rob_flush_id      = '0;
    commit_retired_num       = '0;
    for (int i = 0; i < COMMIT_WIDTH; i++) begin
      commit_rob_retire_id[i*ROB_ID_WIDTH +: ROB_ID_WIDTH] =
          rob_commit_retire_head_id + ROB_ID_WIDTH'(i);
    end
    if (!rst) begin
      unique case (r_state)
        StNormal: begin
          commit_rob_flush_id = rob_commit_flush_tail_id;
          w_chain = rob_commit_retire_head_id_valid;
          // Retire a contiguous prefix only: the first blocked lane stops all younger ones.
          for (int i = 0; i < COMMIT_WIDTH; i++) begin
            w_chain = w_chain & rob_commit_retire_id_valid[i] & w_lane[i][FinBit] &
                      ~w_lane[i][ExcBit];
            commit_rob_retire_pop[i] = w_chain;
            if (w_chain && w_lane[i][RdvBit]) begin
              commit_free_valid[i]       = 1'b1;
              commit_free_id[i*P +: P]   = w_lane[i][OldLsb +: P];
            end
          end
        end
        StWalk: begin
          commit_rob_flush_id = r_walk_ptr;
          if (rob_commit_flush_data[RdvBit]) begin
            commit_rat_restore_valid = 1'b1;
            commit_rat_restore_arch  = rob_commit_flush_data[ArchLsb +: 5];
            commit_rat_restore_phy   = rob_commit_flush_data[OldLsb +: P];
            commit_free_valid[0]     = 1'b1;
            commit_free_id[0 +: P]   = rob_commit_flush_data[NewLsb +: P];
          end
        end
        StDone: begin
          commit_rob_flush      = 1'b1;
          commit_redirect_valid = 1'b1;
          commit_redirect_pc    = r_pc;
        end
        default: ;
      endcase
    end
    for (int i = 0; i < COMMIT_WIDTH; i++) begin
      commit_retired_num = commit_retired_num + NumW'(commit_rob_retire_pop[i]);
    end
  end

endmodule

// File: tb/tb_rob_commit.sv
// Scoreboard bench for rob_commit: a behavioural ROB drives the DUT, expected per-cycle outputs
// are queued as stimulus is applied and compared on the falling edge.
module tb_rob_commit;
  localparam int CW = 4;
  localparam int IW = 5;
  localparam int PW = 6;
  localparam int IT = 2 * PW + 40;

  typedef struct packed {
    logic          finish;
    logic          exc;
    logic [31:0]   pc;
    logic          rdv;
    logic [4:0]    arch;
    logic [PW-1:0] newp;
    logic [PW-1:0] oldp;
  } item_t;

  typedef struct {
    logic [CW-1:0]    pop;
    logic [2:0]       num;
    logic [CW-1:0]    fv;
    logic [CW*PW-1:0] fid;
    logic             rv;
    logic [4:0]       ra;
    logic [PW-1:0]    rp;
    logic             fl;
    logic             dv;
    logic [31:0]      pc;
    logic [CW*IW-1:0] rid;
    logic [IW-1:0]    fptr;
    logic             fchk;
  } exp_t;

  logic             clk, rst;
  logic [IW-1:0]    head_id, tail_id, flush_id, next_id;
  logic             head_valid, tail_valid, next_valid;
  logic [CW*IW-1:0] retire_id;
  logic [CW*IT-1:0] retire_data;
  logic [CW-1:0]    id_valid, pop, free_valid;
  logic [IT-1:0]    flush_data;
  logic             flush, restore_valid, redirect_valid;
  logic [CW*PW-1:0] free_id;
  logic [4:0]       restore_arch;
  logic [PW-1:0]    restore_phy;
  logic [31:0]      redirect_pc;
  logic [2:0]       retired_num;

  item_t         rob [32];
  logic [IW-1:0] head;
  int            count;
  exp_t          sb [$];
  int            total, bad, cyc;

  rob_commit #(.COMMIT_WIDTH(CW), .ROB_ID_WIDTH(IW), .PHY_REG_ID_WIDTH(PW)) dut (
    .clk                             (clk),
    .rst                             (rst),
    .rob_commit_retire_head_id       (head_id),
    .rob_commit_retire_head_id_valid (head_valid),
    .commit_rob_retire_id            (retire_id),
    .rob_commit_retire_data          (retire_data),
    .rob_commit_retire_id_valid      (id_valid),
    .commit_rob_retire_pop           (pop),
    .rob_commit_flush_tail_id        (tail_id),
    .rob_commit_flush_tail_id_valid  (tail_valid),
    .commit_rob_flush_id             (flush_id),
    .rob_commit_flush_data           (flush_data),
    .rob_commit_flush_next_id        (next_id),
    .rob_commit_flush_next_id_valid  (next_valid),
    .commit_rob_flush                (flush),
    .commit_free_id                  (free_id),
    .commit_free_valid               (free_valid),
    .commit_rat_restore_arch         (restore_arch),
    .commit_rat_restore_phy          (restore_phy),
    .commit_rat_restore_valid        (restore_valid),
    .commit_redirect_pc              (redirect_pc),
    .commit_redirect_valid           (redirect_valid),
    .commit_retired_num              (retired_num)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural ROB: lanes read from head, the walk reads wherever the DUT points.
  always_comb begin
    logic [IW-1:0] idx;
    idx        = '0;
    head_id    = head;
    head_valid = (count != 0);
    tail_id    = head + IW'(count - 1);
    tail_valid = (count != 0);
    for (int i = 0; i < CW; i++) begin
      idx = head + IW'(i);
      retire_data[i*IT +: IT] = rob[idx];
      id_valid[i] = (i < count);
    end
    flush_data = rob[flush_id];
    next_id    = flush_id - 1'b1;
    next_valid = (count != 0) && (flush_id != head);
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] req);
    total++;
    if (obs !== req) begin
      bad++;
      $display("FAIL %s cycle %0d: got %0h want %0h", tag, cyc, obs, req);
    end
  endtask

  task automatic put(input logic [IW-1:0] idx, input logic fin, input logic exc, input logic rdv,
                     input logic [31:0] pc);
    rob[idx] = '{finish: fin, exc: exc, pc: pc, rdv: rdv, arch: 5'(idx * 3 + 1),
                 newp: PW'(idx + 33), oldp: PW'(idx * 5 + 2)};
  endtask

  function automatic exp_t exp_base();
    exp_t e;
    e.pop = '0; e.num = '0; e.fv = '0; e.fid = '0; e.rv = 1'b0; e.ra = '0; e.rp = '0;
    e.fl = 1'b0; e.dv = 1'b0; e.pc = '0; e.fptr = '0; e.fchk = 1'b1;
    for (int i = 0; i < CW; i++) e.rid[i*IW +: IW] = head + IW'(i);
    return e;
  endfunction

  function automatic exp_t exp_normal();
    exp_t          e;
    int            n;
    item_t         it;
    logic [IW-1:0] idx;
    e = exp_base();
    e.fptr = head + IW'(count - 1);
    n = 0;
    // Length of the finished, exception-free run starting at head.
    while (n < CW && n < count) begin
      idx = head + IW'(n);
      if (!rob[idx].finish || rob[idx].exc) break;
      n++;
    end
    e.num = 3'(n);
    e.pop = CW'((1 << n) - 1);
    for (int i = 0; i < n; i++) begin
      idx = head + IW'(i);
      it  = rob[idx];
      e.fv[i] = it.rdv;
      if (it.rdv) e.fid[i*PW +: PW] = it.oldp;
    end
    return e;
  endfunction

  function automatic exp_t exp_walk(input logic [IW-1:0] ptr);
    exp_t e;
    e = exp_base();
    e.fptr = ptr;
    if (rob[ptr].rdv) begin
      e.rv = 1'b1; e.ra = rob[ptr].arch; e.rp = rob[ptr].oldp;
      e.fv = 4'b0001; e.fid[PW-1:0] = rob[ptr].newp;
    end
    return e;
  endfunction

  function automatic exp_t exp_done(input logic [31:0] pc);
    exp_t e;
    e = exp_base();
    e.fl = 1'b1; e.dv = 1'b1; e.pc = pc; e.fchk = 1'b0;
    return e;
  endfunction

  task automatic compare_out();
    exp_t e;
    e = sb.pop_front();
    check("retire_id", 64'(retire_id), 64'(e.rid));
    check("pop", 64'(pop), 64'(e.pop));
    check("retired_num", 64'(retired_num), 64'(e.num));
    check("free_valid", 64'(free_valid), 64'(e.fv));
    check("free_id", 64'(free_id), 64'(e.fid));
    check("restore", 64'({restore_valid, restore_arch, restore_phy}), 64'({e.rv, e.ra, e.rp}));
    check("flush", 64'(flush), 64'(e.fl));
    check("redirect", 64'({redirect_valid, redirect_pc}), 64'({e.dv, e.pc}));
    if (e.fchk) check("flush_id", 64'(flush_id), 64'(e.fptr));
  endtask

  task automatic cycle(input exp_t e);
    sb.push_back(e);
    @(negedge clk);
    compare_out();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic normal_step();
    exp_t e;
    e = exp_normal();
    cycle(e);
    head  = head + IW'(e.num);
    count = count - int'(e.num);
  endtask

  task automatic run_exception();
    logic [IW-1:0] ptr;
    logic [31:0]   pc;
    int            n;
    pc = rob[head].pc;
    n  = count;
    cycle(exp_normal());
    ptr = head + IW'(count - 1);
    for (int k = 0; k < n; k++) begin
      cycle(exp_walk(ptr));
      ptr = ptr - 1'b1;
    end
    cycle(exp_done(pc));
    count = 0;
    head  = '0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

  initial begin
    exp_t e;
    total = 0; bad = 0; cyc = 0;
    rst = 1'b1; head = '0; count = 0;
    for (int i = 0; i < 32; i++) put(IW'(i), 1'b0, 1'b0, 1'b0, 32'h0);
    @(posedge clk);
    #1;

    // Reset with a full-looking head: nothing may retire.
    for (int i = 0; i < 4; i++) put(IW'(i), 1'b1, 1'b0, 1'b1, 32'h100 + 32'(i));
    count = 4;
    e = exp_base(); e.fptr = '0; cycle(e);
    cycle(e);
    rst = 1'b0;
    normal_step();

    // Wrap across id 31 -> 0 with four retirements.
    head = 5'd30; count = 4;
    put(5'd30, 1'b1, 1'b0, 1'b1, 32'h200); put(5'd31, 1'b1, 1'b0, 1'b1, 32'h204);
    put(5'd0, 1'b1, 1'b0, 1'b1, 32'h208);  put(5'd1, 1'b1, 1'b0, 1'b1, 32'h20c);
    normal_step();

    // Unfinished lane 1 blocks finished lanes 2-3, then they drain.
    head = 5'd5; count = 4;
    put(5'd5, 1'b1, 1'b0, 1'b1, 32'h300); put(5'd6, 1'b0, 1'b0, 1'b0, 32'h304);
    put(5'd7, 1'b1, 1'b0, 1'b1, 32'h308); put(5'd8, 1'b1, 1'b0, 1'b1, 32'h30c);
    normal_step();
    put(5'd6, 1'b1, 1'b0, 1'b0, 32'h304);
    normal_step();

    // Partial occupancy, then an exception in lane 2 stops the prefix and later heads the ROB.
    head = 5'd9; count = 2;
    put(5'd9, 1'b1, 1'b0, 1'b1, 32'h400); put(5'd10, 1'b1, 1'b0, 1'b0, 32'h404);
    normal_step();
    count = 4;
    put(5'd11, 1'b1, 1'b0, 1'b1, 32'h500); put(5'd12, 1'b1, 1'b0, 1'b1, 32'h504);
    put(5'd13, 1'b1, 1'b1, 1'b1, 32'h508); put(5'd14, 1'b1, 1'b0, 1'b0, 32'h50c);
    normal_step();
    run_exception();

    // Exception at head 3, tail 6: restore 6,5,4,3 then redirect.
    head = 5'd3; count = 4;
    put(5'd3, 1'b1, 1'b1, 1'b1, 32'h8000_0100); put(5'd4, 1'b1, 1'b0, 1'b1, 32'h8000_0104);
    put(5'd5, 1'b0, 1'b0, 1'b1, 32'h8000_0108); put(5'd6, 1'b1, 1'b0, 1'b1, 32'h8000_010c);
    run_exception();
    normal_step();

    // Full ROB: 32 walk cycles then one done pulse.
    head = 5'd7; count = 32;
    for (int k = 0; k < 32; k++) begin
      put(IW'(7 + k), 1'b1, (k == 0), ((k % 3) != 0), 32'h1234_5600 + 32'(k * 4));
    end
    run_exception();

    // Reset on the second walk cycle aborts the walk with no flush or redirect.
    head = 5'd20; count = 3;
    put(5'd20, 1'b1, 1'b1, 1'b1, 32'h600); put(5'd21, 1'b1, 1'b0, 1'b1, 32'h604);
    put(5'd22, 1'b1, 1'b0, 1'b1, 32'h608);
    cycle(exp_normal());
    cycle(exp_walk(5'd22));
    rst = 1'b1;
    e = exp_base(); e.fptr = '0; cycle(e);
    rst = 1'b0; count = 0; head = '0;
    normal_step();
    normal_step();
    put(5'd0, 1'b1, 1'b0, 1'b1, 32'h700); count = 1;
    normal_step();

    // Empty ROB for ten cycles.
    head = 5'd17; count = 0;
    for (int k = 0; k < 10; k++) normal_step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
